alu_op_scheduler: RTL

ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

---
 rtl/alu_op_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/alu_op_scheduler.sv
// rtl/alu_op_scheduler.sv - round-robin scheduler feeding two requesters into one fixed-latency ALU
// Holds one operation in flight; illegal opcodes are answered directly without touching the ALU.
module alu_op_scheduler #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_z,
  output logic             resp_err,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_en,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_z,
  output logic             busy,
  output logic [15:0]      issue_count
);

  localparam logic [3:0] LAT    = 4'(LATENCY);
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MAX = 4'b1011;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESPOND = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_gnt;
  logic             gnt_sel;
  logic             accept;
  logic             sel_legal;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       wait_cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] data_q;
  logic             z_q;
  logic             err_q;
  logic [15:0]      issue_cnt;

  // Both pending: favour the requester not granted last; otherwise take whoever is valid.
  always_comb begin
    gnt_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_sel = ~last_gnt;
    end else if (req1_valid) begin
      gnt_sel = 1'b1;
    end
    sel_op    = gnt_sel ? req1_op : req0_op;
    sel_a     = gnt_sel ? req1_a  : req0_a;
    sel_b     = gnt_sel ? req1_b  : req0_b;
    sel_legal = (sel_op != 4'd0) && (sel_op <= OP_MAX);
    accept    = (state == S_IDLE) && (req0_valid || req1_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = sel_legal ? S_ISSUE : S_RESPOND;
        end
      end
      S_ISSUE:   state_nxt = S_WAIT;
      S_WAIT: begin
        if (wait_cnt == 4'd1) begin
          state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: state_nxt = S_RESPOND;
      S_RESPOND: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready  = accept && !gnt_sel;
    req1_ready  = accept && gnt_sel;
    alu_en      = (state == S_ISSUE);
    resp0_valid = (state == S_RESPOND) && !last_gnt;
    resp1_valid = (state == S_RESPOND) && last_gnt;
    busy        = (state != S_IDLE);
  end

  // last_gnt doubles as the owner of the in-flight operation until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt  <= 1'b1;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      wait_cnt  <= '0;
      data_q    <= '0;
      z_q       <= 1'b0;
      err_q     <= 1'b0;
      issue_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            last_gnt <= gnt_sel;
            op_q     <= sel_op;
            a_q      <= sel_a;
            b_q      <= sel_b;
            if (!sel_legal) begin
              data_q <= '0;
              z_q    <= 1'b0;
              err_q  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          wait_cnt  <= LAT;
          issue_cnt <= issue_cnt + 16'd1;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
        end
        S_CAPTURE: begin
          data_q <= alu_c;
          z_q    <= (op_q == OP_SUB) && alu_z;
          err_q  <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign resp_data   = data_q;
  assign resp_z      = z_q;
  assign resp_err    = err_q;
  assign issue_count = issue_cnt;

endmodule
